// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions (FSM encoding, oversample points, word-length decode).
// Latency : n/a (constants and pure functions only).
// Backpr. : n/a.
// Port summary: none -- package imported by the RX controller and the TX path.
package uart_pkg;

  // Oversample points within one 16-tick bit period.
  localparam logic [3:0] OVS_MID  = 4'd7;
  localparam logic [3:0] OVS_LAST = 4'd15;

  // Receive FSM encoding.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  // Word length select: 00=5, 01=6, 10=7, 11=8 data bits.
  function automatic logic [3:0] wls_to_nbits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose : STAGES-deep flop synchronizer for an asynchronous single-bit input.
// Latency : STAGES clk from d to q.
// Backpr. : none; free-running.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
// Reset value is a parameter so an idle-high serial line stays "idle" through reset.
module uart_sync2 #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic [STAGES:0]   shifted;

  always_comb begin
    shifted = {sync_q, d};
    sync_d  = shifted[STAGES-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose : UART receiver; 16x oversampled start/data/parity/stop decode into the RX FIFO.
// Latency : rx_push 1 clk after the stop-bit sample tick (+SYNC_STAGES clk from rxd).
// Backpr. : none; a frame completing while rx_full_status=1 is dropped and flagged overrun_err.
// Ports: clk/rst_n; rx_tick (16x baud enable); rxd (raw line); PEN/EPS/WLS (frame format,
//        latched at mid start bit); rx_full_status (FIFO full); rx_push/rx_data and
//        parity_err/frame_err/break_det (valid with rx_push); overrun_err pulse; rx_busy.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_tick,
  input  logic       rxd,
  input  logic       PEN,
  input  logic       EPS,
  input  logic [1:0] WLS,
  input  logic       rx_full_status,
  output logic       rx_push,
  output logic [7:0] rx_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVS);

  logic rxs;

  uart_sync2 #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs)
  );

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_reg_q, shift_reg_d;
  // Frame config captured at mid start bit so software writes mid-frame are harmless.
  logic          pen_q, pen_d;
  logic          eps_q, eps_d;
  logic [1:0]    wls_q, wls_d;
  // Running XOR of data bits, running OR of data+parity bits (for break), parity verdict.
  logic          par_acc_q, par_acc_d;
  logic          ones_q, ones_d;
  logic          perr_q, perr_d;
  // Registered outputs.
  logic          rx_push_q, rx_push_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          break_det_q, break_det_d;
  logic          overrun_q, overrun_d;

  logic [3:0]    nbits;
  logic [3:0]    shamt;
  logic          last_bit;
  logic          at_mid;
  logic          at_last;

  always_comb begin
    nbits    = wls_to_nbits(wls_q);
    // Data arrives MSB-side first (shift right), so a short word sits in the top bits.
    shamt    = 4'd8 - nbits;
    last_bit = (bit_cnt_q == 3'(nbits - 4'd1));
    at_mid   = (tick_cnt_q == TW'(OVS_MID));
    at_last  = (tick_cnt_q == TW'(OVS_LAST));
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_reg_d  = shift_reg_q;
    pen_d        = pen_q;
    eps_d        = eps_q;
    wls_d        = wls_q;
    par_acc_d    = par_acc_q;
    ones_d       = ones_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    // Strobes and per-frame flags live for exactly one clk.
    rx_push_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    break_det_d  = 1'b0;
    overrun_d    = 1'b0;

    if (rx_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end

        ST_START: begin
          if (at_mid) begin
            tick_cnt_d = '0;
            if (rxs) begin
              // Glitch shorter than half a bit: not a real start.
              state_d = ST_IDLE;
            end else begin
              state_d     = ST_DATA;
              bit_cnt_d   = '0;
              shift_reg_d = '0;
              pen_d       = PEN;
              eps_d       = EPS;
              wls_d       = WLS;
              par_acc_d   = 1'b0;
              ones_d      = 1'b0;
              perr_d      = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        ST_DATA: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (at_last) begin
            shift_reg_d = {rxs, shift_reg_q[7:1]};
            par_acc_d   = par_acc_q ^ rxs;
            ones_d      = ones_q | rxs;
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (last_bit) begin
              state_d = pen_q ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (at_last) begin
            // Even: total XOR must be 0; odd: must be 1.
            perr_d  = (par_acc_q ^ rxs) ^ ~eps_q;
            ones_d  = ones_q | rxs;
            state_d = ST_STOP;
          end
        end

        ST_STOP: begin
          tick_cnt_d = tick_cnt_q + TW'(1);
          if (at_last) begin
            if (rx_full_status) begin
              overrun_d = 1'b1;
            end else begin
              rx_push_d    = 1'b1;
              rx_data_d    = shift_reg_q >> shamt;
              parity_err_d = perr_q;
              frame_err_d  = ~rxs;
              break_det_d  = ~ones_q & ~rxs;
            end
            // A low line after the stop bit must rise before another start is accepted.
            state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
          end
        end

        ST_WAIT_HIGH: begin
          if (rxs) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_reg_q  <= '0;
      pen_q        <= 1'b0;
      eps_q        <= 1'b0;
      wls_q        <= 2'b00;
      par_acc_q    <= 1'b0;
      ones_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_reg_q  <= shift_reg_d;
      pen_q        <= pen_d;
      eps_q        <= eps_d;
      wls_q        <= wls_d;
      par_acc_q    <= par_acc_d;
      ones_q       <= ones_d;
      perr_q       <= perr_d;
      rx_push_q    <= rx_push_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_push     = rx_push_q;
  assign rx_data     = rx_data_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign break_det   = break_det_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose : self-checking bench for uart_rx_ctrl; expected frames queued at stimulus time.
// Latency : n/a.
// Backpr. : rx_full_status driven directly to exercise the overrun path.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_tick;
  logic       rxd;
  logic       PEN;
  logic       EPS;
  logic [1:0] WLS;
  logic       rx_full_status;
  logic       rx_push;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun_err;
  logic       rx_busy;

  uart_rx_ctrl #(.OVS(16), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tick        (rx_tick),
    .rxd            (rxd),
    .PEN            (PEN),
    .EPS            (EPS),
    .WLS            (WLS),
    .rx_full_status (rx_full_status),
    .rx_push        (rx_push),
    .rx_data        (rx_data),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .break_det      (break_det),
    .overrun_err    (overrun_err),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   fails     = 0;
  int   push_cnt  = 0;
  int   ovr_cnt   = 0;
  int   exp_total = 0;
  int   tick_div  = 1;
  int   tick_ph   = 0;
  logic push_prev = 1'b0;
  logic ovr_prev  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe, input logic bd);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    e.bd   = bd;
    exp_q.push_back(e);
    exp_total++;
  endtask

  // Tick generator: one tick every tick_div clks, updated just after the rising edge.
  initial begin
    rx_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % tick_div;
      rx_tick = (tick_ph == 0);
    end
  end

  // Monitor: pops the scoreboard on every push, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_push) begin
        exp_t e;
        push_cnt++;
        check("push_one_clk", {31'd0, push_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_push: got data 0x%0h, no frame expected", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data",    {24'd0, rx_data},    {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("frame_err",  {31'd0, frame_err},  {31'd0, e.fe});
          check("break_det",  {31'd0, break_det},  {31'd0, e.bd});
        end
      end
      if (overrun_err) begin
        ovr_cnt++;
        check("ovr_one_clk", {31'd0, ovr_prev}, 32'd0);
        check("ovr_no_push", {31'd0, rx_push},  32'd0);
      end
    end
    push_prev = rx_push;
    ovr_prev  = overrun_err;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #2;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_ticks(16);
  endtask

  // Start bit, nb data bits LSB first, optional parity bit, one stop bit.
  // scramble flips the format inputs after the start bit; the DUT must ignore it.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_en,
                            input logic par_bit, input logic stop_bit, input bit scramble);
    logic       pen_s;
    logic       eps_s;
    logic [1:0] wls_s;
    pen_s = PEN;
    eps_s = EPS;
    wls_s = WLS;
    send_bit(1'b0);
    if (scramble) begin
      PEN = ~PEN;
      EPS = ~EPS;
      WLS = ~WLS;
    end
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    send_bit(stop_bit);
    PEN = pen_s;
    EPS = eps_s;
    WLS = wls_s;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n          = 1'b0;
    rxd            = 1'b1;
    PEN            = 1'b0;
    EPS            = 1'b0;
    WLS            = 2'b11;
    rx_full_status = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_push",  {31'd0, rx_push},     32'd0);
    check("reset_data",  {24'd0, rx_data},     32'd0);
    check("reset_busy",  {31'd0, rx_busy},     32'd0);
    check("reset_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
    check("reset_ovr",   {31'd0, overrun_err}, 32'd0);
    rst_n = 1'b1;
    wait_ticks(8);

    // 8N1 0xA5.
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(4);
    check("a5_busy_after", {31'd0, rx_busy}, 32'd0);
    check("a5_data_held",  {24'd0, rx_data}, 32'h0000_00A5);

    // 5-bit even parity, config scrambled mid-frame; then bad parity; then odd parity.
    WLS = 2'b00;
    PEN = 1'b1;
    EPS = 1'b1;
    expect_frame(8'h13, 1'b0, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1, 1'b1, 1'b1, 1);
    rxd = 1'b1;
    wait_ticks(8);
    expect_frame(8'h13, 1'b1, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);
    EPS = 1'b0;
    expect_frame(8'h13, 1'b0, 1'b0, 1'b0);
    send_frame(8'h13, 5, 1, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);

    // False start: 4 ticks low.
    base = push_cnt;
    rxd  = 1'b0;
    wait_ticks(4);
    check("fs_busy_during", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    wait_ticks(32);
    check("fs_busy_after", {31'd0, rx_busy}, 32'd0);
    check("fs_no_push", push_cnt - base, 32'd0);

    // Framing error then held low; break frame; recovery.
    WLS  = 2'b11;
    PEN  = 1'b0;
    base = push_cnt;
    expect_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 8, 0, 1'b0, 1'b0, 0);
    wait_ticks(48);
    check("brk_wait_high_busy", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    wait_ticks(16);
    expect_frame(8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(8'h00, 8, 0, 1'b0, 1'b0, 0);
    wait_ticks(48);
    check("brk_single_push", push_cnt - base, 32'd2);
    rxd = 1'b1;
    wait_ticks(16);
    expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);

    // Overrun: FIFO full through 0x55.
    base           = push_cnt;
    rx_full_status = 1'b1;
    send_frame(8'h55, 8, 0, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);
    rx_full_status = 1'b0;
    check("ovr_count", ovr_cnt, 32'd1);
    check("ovr_no_push_total", push_cnt - base, 32'd0);

    // Reset during data bit 3 of a frame, then 0x81.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b1;
    wait_ticks(8);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("mid_rst_data", {24'd0, rx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_ticks(16);
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);

    // Sparse ticks: 6N1 and 7O1.
    tick_div = 3;
    WLS      = 2'b01;
    PEN      = 1'b0;
    expect_frame(8'h2A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h2A, 6, 0, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);
    WLS = 2'b10;
    PEN = 1'b1;
    EPS = 1'b0;
    expect_frame(8'h45, 1'b0, 1'b0, 1'b0);
    send_frame(8'h45, 7, 1, 1'b0, 1'b1, 0);
    rxd = 1'b1;
    wait_ticks(8);
    tick_div = 1;

    begin
      int budget;
      budget = 1000;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
    end
    check("queue_drained", exp_q.size(), 32'd0);
    check("push_total", push_cnt, exp_total);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
